wr_slot_scheduler: RTL and testbench
====================================

Name: wr_slot_scheduler

Overview:
- Slot allocator and phase sequencer for the per-transaction write-monitor slots on the AXI slave-side write path.
- Allocates a slot on each AW handshake and advances it WRITE_ADDRESS -> WRITE_DATA -> WRITE_RESPONSE from W and B handshakes.
- Frees the slot on the matching B handshake.
- Runs a per-slot phase timer on prescaled ticks and flags slots whose current phase exceeds its programmed budget.

Parameters:
NumSlots, 4, number of outstanding write transactions tracked (2..16)
IdWidth, 4, AXI ID width
CntWidth, 8, phase timer and budget width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
prescaled_en_i  in  1  timer tick enable
aw_valid_i  in  1  AW valid
aw_ready_i  in  1  AW ready
aw_id_i  in  IdWidth  AW ID
w_valid_i  in  1  W valid
w_ready_i  in  1  W ready
w_last_i  in  1  W last
b_valid_i  in  1  B valid
b_ready_i  in  1  B ready
b_id_i  in  IdWidth  B ID
budget_aw_i  in  CntWidth  tick budget for WRITE_ADDRESS
budget_w_i  in  CntWidth  tick budget for WRITE_DATA
budget_b_i  in  CntWidth  tick budget for WRITE_RESPONSE
clear_i  in  1  clears all sticky flags
full_o  out  1  all slots busy; upstream gates AW ready with it
slot_busy_o  out  NumSlots  per-slot in-use
slot_state_o  out  2*NumSlots  per-slot phase: 0 ADDRESS, 1 DATA, 2 RESPONSE
timeout_o  out  NumSlots  one-cycle pulse when a slot's timer reaches its budget
irq_o  out  1  sticky OR of any timeout
err_overflow_o  out  1  sticky: AW handshake while full
err_orphan_w_o  out  1  sticky: W handshake with no outstanding AW
err_unmatched_b_o  out  1  sticky: B handshake with no RESPONSE slot of that ID

Behaviour:
- Reset: all slots free, timers 0, order FIFO empty, age matrix 0. All outputs 0 except full_o=0. Reset is asynchronous and may assert mid-transaction; everything is discarded.
- Allocation:
  - On aw_valid_i && aw_ready_i && !full_o, take the lowest-index free slot from the registered free vector.
  - The slot stores aw_id_i, state=ADDRESS, timer=0.
  - Its index is pushed to the write-order FIFO (depth NumSlots).
  - Its age row is set older-than-none; all busy slots are marked older than it.
  - Effect is visible the next cycle.
- A slot freed in cycle N is not reallocated in cycle N; it is allocatable from N+1.
- full_o is combinational from the registered busy vector: 1 iff all slots are busy.
- AW handshake while full: ignored; err_overflow_o set.
- W tracking (W carries no ID; it belongs to the FIFO head slot):
  - Head in ADDRESS and w_valid_i: go to DATA, timer=0.
  - Head in ADDRESS or DATA and w_valid_i && w_ready_i && w_last_i: go to RESPONSE, timer=0, pop FIFO. This includes a single-beat burst going ADDRESS->RESPONSE in one cycle.
  - W handshake with empty FIFO: ignored; err_orphan_w_o set.
- B tracking:
  - On b_valid_i && b_ready_i, select the oldest slot (per age matrix) in RESPONSE with stored ID == b_id_i.
  - That slot is freed, its timer cleared, and its age row and column cleared.
  - No match: err_unmatched_b_o set.
- Simultaneous AW alloc, W last and B free in one cycle: all are applied independently. The FIFO supports push and pop in the same cycle.
- Timers:
  - A busy slot's timer increments on prescaled_en_i and saturates at all-ones.
  - It is compared against the budget for the slot's current state.
  - When the timer == budget and prescaled_en_i, timeout_o[i] pulses for one cycle and irq_o is set.
  - A slot pulses at most once per phase. A per-slot flag is set on the pulse and cleared on phase change.
  - Budget 0 disables the check for that phase.
- clear_i clears irq_o and err_*; a new event in the same cycle wins (flag stays set).
- Phase transitions reset the timer regardless of prescaled_en_i.

Test Plan:
1. Reset, budgets 0; AW id=3, one W beat with last, B id=3 -> slot0 states ADDRESS, RESPONSE, then free; slot_busy_o 0001 then 0000; no errors.
2. Four AWs (ids 1,2,3,4), no W -> full_o=1 after the 4th. A 5th AW handshake sets err_overflow_o; slot_busy_o stays 1111.
3. Two AWs with same id=5, 4-beat bursts each, one B id=5 -> slot0 (older) freed, slot1 remains RESPONSE. A second B frees slot1.
4. budget_aw_i=3, prescaled_en_i every cycle, AW with no W -> timeout_o[0] pulses exactly once, 3 ticks after allocation; irq_o stays 1 until clear_i.
5. Same cycle: B frees slot0 and AW arrives with slots 0-3 busy -> AW flagged as overflow. The next AW is allocated to slot0.
6. W handshake with no AW outstanding -> err_orphan_w_o=1. B id=7 with no slot of id 7 -> err_unmatched_b_o=1. Assert rst_ni mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/wr_slot_scheduler.sv
// Write-path slot allocator: tracks outstanding AXI writes through the address, data
// and response phases, with per-slot phase timers and sticky protocol error flags.
module wr_slot_scheduler #(
    parameter int NumSlots = 4,
    parameter int IdWidth  = 4,
    parameter int CntWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  prescaled_en_i,
    input  logic                  aw_valid_i,
    input  logic                  aw_ready_i,
    input  logic [IdWidth-1:0]    aw_id_i,
    input  logic                  w_valid_i,
    input  logic                  w_ready_i,
    input  logic                  w_last_i,
    input  logic                  b_valid_i,
    input  logic                  b_ready_i,
    input  logic [IdWidth-1:0]    b_id_i,
    input  logic [CntWidth-1:0]   budget_aw_i,
    input  logic [CntWidth-1:0]   budget_w_i,
    input  logic [CntWidth-1:0]   budget_b_i,
    input  logic                  clear_i,
    output logic                  full_o,
    output logic [NumSlots-1:0]   slot_busy_o,
    output logic [2*NumSlots-1:0] slot_state_o,
    output logic [NumSlots-1:0]   timeout_o,
    output logic                  irq_o,
    output logic                  err_overflow_o,
    output logic                  err_orphan_w_o,
    output logic                  err_unmatched_b_o
);

    localparam int SlotW  = $clog2(NumSlots);
    localparam int CountW = $clog2(NumSlots + 1);

    typedef enum logic [1:0] {
        PHASE_ADDR = 2'd0,
        PHASE_DATA = 2'd1,
        PHASE_RESP = 2'd2
    } phase_e;

    logic [NumSlots-1:0] busy_q;
    logic [NumSlots-1:0] fired_q;
    phase_e              phase_q [NumSlots];
    logic [IdWidth-1:0]  id_q    [NumSlots];
    logic [CntWidth-1:0] timer_q [NumSlots];
    // age_q[i][j] set means slot i was allocated before slot j
    logic [NumSlots-1:0] age_q   [NumSlots];
    logic [SlotW-1:0]    fifo_q  [NumSlots];
    logic [SlotW-1:0]    rd_ptr_q;
    logic [SlotW-1:0]    wr_ptr_q;
    logic [CountW-1:0]   count_q;

    logic                aw_hs;
    logic                w_hs;
    logic                b_hs;
    logic                alloc;
    logic                fifo_empty;
    logic                head_to_data;
    logic                head_to_resp;
    logic [SlotW-1:0]    alloc_idx;
    logic [SlotW-1:0]    head_idx;
    logic [NumSlots-1:0] b_cand;
    logic [NumSlots-1:0] b_free;
    logic [NumSlots-1:0] hit;
    logic [CntWidth-1:0] budget_sel [NumSlots];

    function automatic logic [SlotW-1:0] next_ptr(input logic [SlotW-1:0] ptr);
        return (ptr == SlotW'(NumSlots - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o       = &busy_q;
    assign slot_busy_o  = busy_q;
    assign aw_hs        = aw_valid_i & aw_ready_i;
    assign w_hs         = w_valid_i & w_ready_i;
    assign b_hs         = b_valid_i & b_ready_i;
    assign alloc        = aw_hs & ~full_o;
    assign fifo_empty   = (count_q == '0);
    assign head_idx     = fifo_q[rd_ptr_q];
    assign head_to_resp = ~fifo_empty & w_hs & w_last_i;
    assign head_to_data = ~fifo_empty & w_valid_i & ~head_to_resp
                          & (phase_q[head_idx] == PHASE_ADDR);

    always_comb begin
        alloc_idx = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_idx = SlotW'(i);
        end
    end

    always_comb begin
        b_cand = '0;
        for (int i = 0; i < NumSlots; i++) begin
            b_cand[i] = busy_q[i] && (phase_q[i] == PHASE_RESP) && (id_q[i] == b_id_i);
        end
    end

    // The oldest candidate is the one no other candidate is older than
    always_comb begin
        logic older;
        logic found;
        b_free = '0;
        older  = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
            older = 1'b0;
            for (int j = 0; j < NumSlots; j++) begin
                if (b_cand[j] && age_q[j][i]) older = 1'b1;
            end
            if (b_hs && b_cand[i] && !older && !found) begin
                b_free[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int i = 0; i < NumSlots; i++) begin
            case (phase_q[i])
                PHASE_ADDR: budget_sel[i] = budget_aw_i;
                PHASE_DATA: budget_sel[i] = budget_w_i;
                default:    budget_sel[i] = budget_b_i;
            endcase
            hit[i] = busy_q[i] && prescaled_en_i && !fired_q[i]
                     && (budget_sel[i] != '0) && (timer_q[i] == budget_sel[i]);
        end
    end

    always_comb begin
        slot_state_o = '0;
        for (int i = 0; i < NumSlots; i++) begin
            slot_state_o[2*i +: 2] = phase_q[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            fired_q <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                phase_q[i] <= PHASE_ADDR;
                id_q[i]    <= '0;
                timer_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                if (b_free[i]) begin
                    busy_q[i]  <= 1'b0;
                    phase_q[i] <= PHASE_ADDR;
                    timer_q[i] <= '0;
                    fired_q[i] <= 1'b0;
                end else if (alloc && (alloc_idx == SlotW'(i))) begin
                    busy_q[i]  <= 1'b1;
                    id_q[i]    <= aw_id_i;
                    phase_q[i] <= PHASE_ADDR;
                    timer_q[i] <= '0;
                    fired_q[i] <= 1'b0;
                end else if ((head_to_data || head_to_resp) && (head_idx == SlotW'(i))) begin
                    phase_q[i] <= head_to_resp ? PHASE_RESP : PHASE_DATA;
                    timer_q[i] <= '0;
                    fired_q[i] <= 1'b0;
                end else if (busy_q[i]) begin
                    if (prescaled_en_i && (timer_q[i] != '1)) timer_q[i] <= timer_q[i] + 1'b1;
                    if (hit[i]) fired_q[i] <= 1'b1;
                end
            end
        end
    end

    // A freed slot's row and column are cleared even if it is also named by a new allocation
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumSlots; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < NumSlots; i++) begin
                for (int j = 0; j < NumSlots; j++) begin
                    if (b_free[i] || b_free[j]) begin
                        age_q[i][j] <= 1'b0;
                    end else if (alloc && (alloc_idx == SlotW'(i))) begin
                        age_q[i][j] <= 1'b0;
                    end else if (alloc && (alloc_idx == SlotW'(j)) && busy_q[i]) begin
                        age_q[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < NumSlots; i++) fifo_q[i] <= '0;
        end else begin
            if (alloc) begin
                fifo_q[wr_ptr_q] <= alloc_idx;
                wr_ptr_q         <= next_ptr(wr_ptr_q);
            end
            if (head_to_resp) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({alloc, head_to_resp})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_o         <= '0;
            irq_o             <= 1'b0;
            err_overflow_o    <= 1'b0;
            err_orphan_w_o    <= 1'b0;
            err_unmatched_b_o <= 1'b0;
        end else begin
            timeout_o         <= hit;
            irq_o             <= (|hit) | (irq_o & ~clear_i);
            err_overflow_o    <= (aw_hs & full_o) | (err_overflow_o & ~clear_i);
            err_orphan_w_o    <= (w_hs & fifo_empty) | (err_orphan_w_o & ~clear_i);
            err_unmatched_b_o <= (b_hs & ~(|b_cand)) | (err_unmatched_b_o & ~clear_i);
        end
    end

endmodule

// File: tb/tb_wr_slot_scheduler.sv
// Testbench for wr_slot_scheduler: constant vector table, directed corner sequences and
// randomized traffic compared every cycle against a transaction-level reference model.
module tb_wr_slot_scheduler;

    localparam int NS   = 4;
    localparam int IW   = 4;
    localparam int CW   = 8;
    localparam int TMAX = (1 << CW) - 1;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready, clear;
    logic [IW-1:0]   aw_id, b_id;
    logic [CW-1:0]   budget_aw, budget_w, budget_b;
    logic            full, irq, err_ovf, err_orph, err_unm;
    logic [NS-1:0]   slot_busy, timeout;
    logic [2*NS-1:0] slot_state;

    wr_slot_scheduler #(.NumSlots(NS), .IdWidth(IW), .CntWidth(CW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .prescaled_en_i   (en),
        .aw_valid_i       (aw_valid),
        .aw_ready_i       (aw_ready),
        .aw_id_i          (aw_id),
        .w_valid_i        (w_valid),
        .w_ready_i        (w_ready),
        .w_last_i         (w_last),
        .b_valid_i        (b_valid),
        .b_ready_i        (b_ready),
        .b_id_i           (b_id),
        .budget_aw_i      (budget_aw),
        .budget_w_i       (budget_w),
        .budget_b_i       (budget_b),
        .clear_i          (clear),
        .full_o           (full),
        .slot_busy_o      (slot_busy),
        .slot_state_o     (slot_state),
        .timeout_o        (timeout),
        .irq_o            (irq),
        .err_overflow_o   (err_ovf),
        .err_orphan_w_o   (err_orph),
        .err_unmatched_b_o(err_unm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         aw;
        logic [3:0] aw_id;
        bit         wv;
        bit         wr;
        bit         wl;
        bit         b;
        logic [3:0] b_id;
        bit         clr;
        logic [3:0] e_busy;
        logic [7:0] e_state;
        bit         e_full;
        logic [2:0] e_err;
    } vec_t;

    vec_t vecs[19];

    // Reference model: slots carry an allocation serial number instead of an age matrix
    bit      m_busy  [NS];
    int      m_id    [NS];
    int      m_phase [NS];
    int      m_timer [NS];
    bit      m_fired [NS];
    int      m_seq   [NS];
    int      m_serial;
    int      m_order [$];
    bit [NS-1:0] m_timeout;
    bit      m_irq, m_ovf, m_orph, m_unm;

    int checks;
    int passes;

    task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic int budgetFor(input int ph);
        if (ph == 0) return int'(budget_aw);
        if (ph == 1) return int'(budget_w);
        return int'(budget_b);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NS; i++) begin
            m_busy[i] = 0; m_id[i] = 0; m_phase[i] = 0;
            m_timer[i] = 0; m_fired[i] = 0; m_seq[i] = 0;
        end
        m_serial = 0;
        m_order.delete();
        m_timeout = '0;
        m_irq = 0; m_ovf = 0; m_orph = 0; m_unm = 0;
    endtask

    task automatic modelStep();
        bit busy0[NS];
        int phase0[NS];
        int timer0[NS];
        int id0[NS];
        bit fired0[NS];
        bit touched[NS];
        bit hit[NS];
        bit pre_full, any_hit, ovf_ev, orph_ev, unm_ev;
        int best, slot, h, bud;
        pre_full = 1; any_hit = 0; ovf_ev = 0; orph_ev = 0; unm_ev = 0;
        for (int i = 0; i < NS; i++) begin
            busy0[i] = m_busy[i]; phase0[i] = m_phase[i]; timer0[i] = m_timer[i];
            id0[i] = m_id[i]; fired0[i] = m_fired[i]; touched[i] = 0; hit[i] = 0;
            if (!m_busy[i]) pre_full = 0;
        end
        for (int i = 0; i < NS; i++) begin
            bud = budgetFor(phase0[i]);
            if (busy0[i] && en && bud != 0 && timer0[i] == bud && !fired0[i]) begin
                hit[i] = 1;
                any_hit = 1;
            end
        end
        if (m_order.size() > 0) begin
            h = m_order[0];
            if (w_valid && w_ready && w_last) begin
                m_phase[h] = 2; m_timer[h] = 0; m_fired[h] = 0; touched[h] = 1;
                void'(m_order.pop_front());
            end else if (w_valid && phase0[h] == 0) begin
                m_phase[h] = 1; m_timer[h] = 0; m_fired[h] = 0; touched[h] = 1;
            end
        end else if (w_valid && w_ready) begin
            orph_ev = 1;
        end
        if (b_valid && b_ready) begin
            best = -1;
            for (int i = 0; i < NS; i++) begin
                if (busy0[i] && phase0[i] == 2 && id0[i] == int'(b_id)
                    && (best < 0 || m_seq[i] < m_seq[best])) best = i;
            end
            if (best < 0) unm_ev = 1;
            else begin
                m_busy[best] = 0; m_phase[best] = 0; m_timer[best] = 0;
                m_fired[best] = 0; touched[best] = 1;
            end
        end
        if (aw_valid && aw_ready) begin
            if (pre_full) ovf_ev = 1;
            else begin
                slot = -1;
                for (int i = 0; i < NS; i++) if (!busy0[i] && slot < 0) slot = i;
                m_busy[slot] = 1; m_id[slot] = int'(aw_id); m_phase[slot] = 0;
                m_timer[slot] = 0; m_fired[slot] = 0; touched[slot] = 1;
                m_seq[slot] = m_serial; m_serial++;
                m_order.push_back(slot);
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (busy0[i] && !touched[i]) begin
                if (en && timer0[i] < TMAX) m_timer[i] = timer0[i] + 1;
                if (hit[i]) m_fired[i] = 1;
            end
            m_timeout[i] = hit[i];
        end
        m_irq  = any_hit | (m_irq & !clear);
        m_ovf  = ovf_ev  | (m_ovf & !clear);
        m_orph = orph_ev | (m_orph & !clear);
        m_unm  = unm_ev  | (m_unm & !clear);
    endtask

    task automatic checkOutput(input string tag);
        logic [NS-1:0]   eb;
        logic [2*NS-1:0] es;
        for (int i = 0; i < NS; i++) begin
            eb[i] = m_busy[i];
            es[2*i +: 2] = 2'(m_phase[i]);
        end
        checkField({tag, " busy"}, 32'(slot_busy), 32'(eb));
        checkField({tag, " state"}, 32'(slot_state), 32'(es));
        checkField({tag, " full"}, 32'(full), 32'(&eb));
        checkField({tag, " timeout"}, 32'(timeout), 32'(m_timeout));
        checkField({tag, " irq"}, 32'(irq), 32'(m_irq));
        checkField({tag, " err"}, 32'({err_ovf, err_orph, err_unm}), 32'({m_ovf, m_orph, m_unm}));
    endtask

    task automatic applyStimulus(input bit awv, input bit awr, input int awid,
                                 input bit wv, input bit wr, input bit wl,
                                 input bit bv, input bit br, input int bid,
                                 input bit clr, input bit tick, input string tag);
        @(negedge clk);
        aw_valid = awv; aw_ready = awr; aw_id = IW'(awid);
        w_valid = wv; w_ready = wr; w_last = wl;
        b_valid = bv; b_ready = br; b_id = IW'(bid);
        clear = clr; en = tick;
        modelStep();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic zeroInputs();
        aw_valid = 0; aw_ready = 0; aw_id = '0; w_valid = 0; w_ready = 0; w_last = 0;
        b_valid = 0; b_ready = 0; b_id = '0; clear = 0; en = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 0;
        zeroInputs();
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        checkOutput("reset");
    endtask

    task automatic awReq(input int id, input bit tick, input string tag);
        applyStimulus(1, 1, id, 0, 0, 0, 0, 0, 0, 0, tick, tag);
    endtask

    task automatic wBeat(input bit last, input string tag);
        applyStimulus(0, 0, 0, 1, 1, last, 0, 0, 0, 0, 0, tag);
    endtask

    task automatic bResp(input int id, input string tag);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, id, 0, 0, tag);
    endtask

    task automatic idle(input bit tick, input bit clr, input string tag);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, clr, tick, tag);
    endtask

    initial begin
        int pulses;
        int pulse_at;
        checks = 0;
        passes = 0;
        rst_n = 0;
        zeroInputs();
        budget_aw = '0; budget_w = '0; budget_b = '0;

        // aw id wv wr wl b bid clr | busy state full {ovf,orph,unm}
        vecs = '{
            '{1, 3, 0, 0, 0, 0, 0, 0, 4'b0001, 8'h00, 0, 3'b000},
            '{0, 0, 1, 1, 1, 0, 0, 0, 4'b0001, 8'h02, 0, 3'b000},
            '{0, 0, 0, 0, 0, 1, 3, 0, 4'b0000, 8'h00, 0, 3'b000},
            '{1, 1, 0, 0, 0, 0, 0, 0, 4'b0001, 8'h00, 0, 3'b000},
            '{1, 2, 0, 0, 0, 0, 0, 0, 4'b0011, 8'h00, 0, 3'b000},
            '{1, 3, 0, 0, 0, 0, 0, 0, 4'b0111, 8'h00, 0, 3'b000},
            '{1, 4, 0, 0, 0, 0, 0, 0, 4'b1111, 8'h00, 1, 3'b000},
            '{1, 6, 0, 0, 0, 0, 0, 0, 4'b1111, 8'h00, 1, 3'b100},
            '{0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 8'h00, 1, 3'b000},
            '{0, 0, 0, 0, 0, 1, 7, 0, 4'b1111, 8'h00, 1, 3'b001},
            '{0, 0, 0, 0, 0, 0, 0, 1, 4'b1111, 8'h00, 1, 3'b000},
            '{0, 0, 1, 0, 0, 0, 0, 0, 4'b1111, 8'h01, 1, 3'b000},
            '{0, 0, 1, 1, 1, 0, 0, 0, 4'b1111, 8'h02, 1, 3'b000},
            '{0, 0, 0, 0, 0, 1, 1, 0, 4'b1110, 8'h00, 0, 3'b000},
            '{1, 9, 0, 0, 0, 0, 0, 0, 4'b1111, 8'h00, 1, 3'b000},
            '{0, 0, 1, 1, 1, 0, 0, 0, 4'b1111, 8'h08, 1, 3'b000},
            '{1, 10, 0, 0, 0, 1, 2, 0, 4'b1101, 8'h00, 0, 3'b100},
            '{1, 11, 0, 0, 0, 0, 0, 0, 4'b1111, 8'h00, 1, 3'b100},
            '{0, 0, 1, 1, 0, 0, 0, 0, 4'b1111, 8'h10, 1, 3'b100}
        };

        doReset();
        for (int k = 0; k < 19; k++) begin
            applyStimulus(vecs[k].aw, vecs[k].aw, int'(vecs[k].aw_id), vecs[k].wv, vecs[k].wr,
                          vecs[k].wl, vecs[k].b, vecs[k].b, int'(vecs[k].b_id), vecs[k].clr, 0,
                          $sformatf("vec%0d", k));
            checkField($sformatf("vec%0d const busy", k), 32'(slot_busy), 32'(vecs[k].e_busy));
            checkField($sformatf("vec%0d const state", k), 32'(slot_state), 32'(vecs[k].e_state));
            checkField($sformatf("vec%0d const full", k), 32'(full), 32'(vecs[k].e_full));
            checkField($sformatf("vec%0d const err", k), 32'({err_ovf, err_orph, err_unm}),
                       32'(vecs[k].e_err));
        end

        // Same ID twice: the older slot answers the first B
        doReset();
        awReq(5, 0, "same_id aw0");
        awReq(5, 0, "same_id aw1");
        for (int t = 0; t < 8; t++) wBeat((t % 4) == 3, "same_id w");
        checkField("same_id both resp", 32'(slot_state), 32'(8'b0000_1010));
        bResp(5, "same_id b0");
        checkField("same_id first free", 32'(slot_busy), 32'(4'b0010));
        bResp(5, "same_id b1");
        checkField("same_id second free", 32'(slot_busy), 32'(4'b0000));

        // Older transaction sits in the higher-index slot
        doReset();
        awReq(1, 0, "age aw0");
        awReq(5, 0, "age aw1");
        wBeat(1, "age w0");
        bResp(1, "age b0");
        awReq(5, 0, "age aw2");
        wBeat(1, "age w1");
        wBeat(1, "age w2");
        bResp(5, "age b1");
        checkField("age oldest freed", 32'(slot_busy), 32'(4'b0001));
        checkField("age survivor resp", 32'(slot_state), 32'(8'b0000_0010));

        // Address-phase budget of three ticks
        doReset();
        budget_aw = CW'(3);
        awReq(0, 1, "budget aw");
        pulses = 0;
        pulse_at = -1;
        for (int k = 1; k <= 8; k++) begin
            idle(1, 0, "budget idle");
            if (timeout[0]) begin
                pulses++;
                pulse_at = k;
            end
        end
        checkField("budget pulse count", 32'(pulses), 32'd1);
        checkField("budget pulse cycle", 32'(pulse_at), 32'd4);
        checkField("budget irq held", 32'(irq), 32'd1);
        idle(1, 1, "budget clear");
        checkField("budget irq cleared", 32'(irq), 32'd0);

        // Timer saturates at all-ones and fires only once at the maximum budget
        doReset();
        budget_aw = CW'(TMAX);
        awReq(2, 1, "sat aw");
        pulses = 0;
        for (int k = 0; k < 600; k++) begin
            idle(1, 0, "sat idle");
            if (timeout[0]) pulses++;
        end
        checkField("sat pulse count", 32'(pulses), 32'd1);
        budget_aw = '0;

        // Protocol errors, then an asynchronous reset in the middle of a burst
        doReset();
        wBeat(1, "orphan w");
        checkField("orphan flag", 32'(err_orph), 32'd1);
        bResp(7, "unmatched b");
        checkField("unmatched flag", 32'(err_unm), 32'd1);
        awReq(2, 0, "mid aw");
        wBeat(0, "mid w");
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        checkField("async busy", 32'(slot_busy), 32'd0);
        checkField("async state", 32'(slot_state), 32'd0);
        checkField("async full", 32'(full), 32'd0);
        checkField("async irq", 32'(irq), 32'd0);
        checkField("async timeout", 32'(timeout), 32'd0);
        checkField("async err", 32'({err_ovf, err_orph, err_unm}), 32'd0);
        zeroInputs();
        modelReset();
        @(negedge clk);
        rst_n = 1;
        #1;
        checkOutput("post async");

        // Randomized traffic against the model
        for (int seg = 0; seg < 8; seg++) begin
            budget_aw = CW'($urandom_range(0, 6));
            budget_w  = CW'($urandom_range(0, 6));
            budget_b  = CW'($urandom_range(0, 6));
            doReset();
            for (int c = 0; c < 400; c++) begin
                applyStimulus(($urandom % 3) == 0, ($urandom % 4) != 0, int'($urandom_range(0, 3)),
                              ($urandom % 2) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
                              ($urandom % 3) == 0, ($urandom % 4) != 0, int'($urandom_range(0, 3)),
                              ($urandom % 20) == 0, ($urandom % 2) == 0,
                              $sformatf("rnd%0d.%0d", seg, c));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
